mix_pipe: RTL and testbench

//  Parametrised, pipelined successor of the combinational NAND mix benchmark.

---
 rtl/mix_pkg.sv | 36 +++
 rtl/mix_core.sv | 23 ++
 rtl/mix_pipe.sv | 119 +++++++++++
 tb/tb_mix_pipe.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mix_pkg.sv
// Shared types and the c17-style NAND core equations for the mix pipeline.
// Helpers operate on a single bit; the core module replicates them over the vector.
package mix_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_FOLD = 2'd1,
        MODE_SIG  = 2'd2
    } mode_e;

    // Returns {o16, o17} for one bit position.
    function automatic logic [1:0] nand_core(
        input logic a,
        input logic b,
        input logic c,
        input logic d,
        input logic e
    );
        logic n8, n9, n12, n15;
        n8  = ~(a & c);
        n9  = ~(c & d);
        n12 = ~(b & n9);
        n15 = ~(n9 & e);
        return {~(n8 & n12), ~(n12 & n15)};
    endfunction

    // Encoding 3 has no enum member; it behaves as PASS.
    function automatic mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'd1:    return MODE_FOLD;
            2'd2:    return MODE_SIG;
            default: return MODE_PASS;
        endcase
    endfunction

endpackage

// File: rtl/mix_core.sv
// Combinational NAND network applied bitwise across the packed LANES*WIDTH operands.
module mix_core
    import mix_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] c,
    input  logic [N-1:0] d,
    input  logic [N-1:0] e,
    output logic [N-1:0] o16,
    output logic [N-1:0] o17
);

    for (genvar i = 0; i < N; i++) begin : g_bit
        logic [1:0] r;
        assign r      = nand_core(a[i], b[i], c[i], d[i], e[i]);
        assign o16[i] = r[1];
        assign o17[i] = r[0];
    end

endmodule

// File: rtl/mix_pipe.sv
// Two-stage valid/ready pipeline around mix_core with mode fold, per-lane
// rotating signature registers and a saturating delivered-beat counter.
module mix_pipe
    import mix_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int LANES   = 2,
    parameter int COUNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*WIDTH-1:0]   in_a,
    input  logic [LANES*WIDTH-1:0]   in_b,
    input  logic [LANES*WIDTH-1:0]   in_c,
    input  logic [LANES*WIDTH-1:0]   in_d,
    input  logic [LANES*WIDTH-1:0]   in_e,
    input  logic [1:0]               mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*WIDTH-1:0]   out_p,
    output logic [LANES*WIDTH-1:0]   out_q,
    output logic [LANES*WIDTH-1:0]   out_sig,
    output logic [COUNT_W-1:0]       txn_count
);

    localparam int N = LANES * WIDTH;

    logic [N-1:0] c_o16, c_o17;

    mix_core #(.N(N)) u_core (
        .a   (in_a),
        .b   (in_b),
        .c   (in_c),
        .d   (in_d),
        .e   (in_e),
        .o16 (c_o16),
        .o17 (c_o17)
    );

    // Handshake: each stage loads when empty or when its contents move on.
    logic s1_valid, s2_load, s1_load, s1_xfer;
    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;
    assign s1_xfer  = s1_valid && s2_load;

    logic [N-1:0]                    s1_o16;
    logic [LANES-1:0][WIDTH-1:0]     s1_o17;
    mode_e                           s1_mode;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_o16   <= '0;
            s1_o17   <= '0;
            s1_mode  <= MODE_PASS;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_o16  <= c_o16;
                s1_o17  <= c_o17;
                s1_mode <= decode_mode(mode);
            end
        end
    end

    logic [N-1:0] p_nxt, q_nxt;
    always_comb begin
        p_nxt = s1_o16;
        q_nxt = s1_o17;
        if (s1_mode == MODE_FOLD) begin
            p_nxt = s1_o16 ^ s1_o17;
            q_nxt = ~(s1_o16 | s1_o17);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_p     <= '0;
            out_q     <= '0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_p <= p_nxt;
                out_q <= q_nxt;
            end
        end
    end

    // Per-lane signature: rotate left by one, fold in the lane's o17 slice.
    logic [LANES-1:0][WIDTH-1:0] sig_q;
    logic                        sig_upd;
    assign sig_upd = s1_xfer && (s1_mode == MODE_SIG);

    for (genvar l = 0; l < LANES; l++) begin : g_sig
        logic [WIDTH-1:0] rot;
        assign rot = (sig_q[l] << 1) | (sig_q[l] >> (WIDTH - 1));

        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                sig_q[l] <= '0;
            else if (sig_upd)
                sig_q[l] <= rot ^ s1_o17[l];
        end
    end

    assign out_sig = sig_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            txn_count <= '0;
        else if (out_valid && out_ready && (txn_count != {COUNT_W{1'b1}}))
            txn_count <= txn_count + COUNT_W'(1);
    end

endmodule

// File: tb/tb_mix_pipe.sv
// Directed bench for mix_pipe: modes, signature, backpressure, counter saturation, async reset.
module tb_mix_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, out_ready;
    logic [7:0] in_a, in_b, in_c, in_d, in_e;
    logic [1:0] mode;

    logic       in_ready, out_valid;
    logic [7:0] out_p, out_q, out_sig, txn_count;

    logic       s_in_ready, s_out_valid;
    logic [7:0] s_out_p, s_out_q, s_out_sig;
    logic [1:0] s_txn;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mix_pipe #(.WIDTH(4), .LANES(2), .COUNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d), .in_e(in_e),
        .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .out_p(out_p), .out_q(out_q), .out_sig(out_sig), .txn_count(txn_count)
    );

    mix_pipe #(.WIDTH(4), .LANES(2), .COUNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d), .in_e(in_e),
        .mode(mode), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_p(s_out_p), .out_q(s_out_q), .out_sig(s_out_sig), .txn_count(s_txn)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input logic [1:0] m, input logic [7:0] a, b, c, d, e);
        mode = m; in_a = a; in_b = b; in_c = c; in_d = d; in_e = e;
    endtask

    // Present one beat for a single cycle; caller guarantees in_ready=1.
    task automatic send(input logic [1:0] m, input logic [7:0] a, b, c, d, e);
        set_ops(m, a, b, c, d, e);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        set_ops(2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        step(); step();
        rst = 1'b0;
        step();
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ready",  32'(in_ready),  32'h1);
        chk("rst_sig",       32'(out_sig),   32'h0);
        chk("rst_txn",       32'(txn_count), 32'h0);
        chk("rst_p",         32'(out_p),     32'h0);

        // PASS: o16=1, o17=0 everywhere
        send(2'd0, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF);
        chk("pass_latency1", 32'(out_valid), 32'h0);
        step();
        chk("pass_valid", 32'(out_valid), 32'h1);
        chk("pass_p",     32'(out_p),     32'hFF);
        chk("pass_q",     32'(out_q),     32'h00);
        step();
        chk("pass_txn",   32'(txn_count), 32'h1);
        chk("pass_drain", 32'(out_valid), 32'h0);

        // FOLD with o16=o17=1, then all-zero operands (o16=o17=0)
        send(2'd1, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF);
        step();
        chk("fold11_p", 32'(out_p), 32'h00);
        chk("fold11_q", 32'(out_q), 32'h00);
        send(2'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        step();
        chk("fold00_p", 32'(out_p), 32'h00);
        chk("fold00_q", 32'(out_q), 32'hFF);

        // mode 3 behaves as PASS
        send(2'd3, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF);
        step();
        chk("mode3_p", 32'(out_p), 32'hFF);
        chk("mode3_q", 32'(out_q), 32'h00);
        chk("mode3_sig", 32'(out_sig), 32'h00);

        // SIG: lane sig = rotl1(sig) ^ o17.  o17=F: 0->F, F->0; o17=1: 0->1, 1->3
        send(2'd2, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF);
        step();
        chk("sig1", 32'(out_sig), 32'hFF);
        chk("sig1_p", 32'(out_p), 32'hFF);
        chk("sig1_q", 32'(out_q), 32'hFF);
        send(2'd2, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF);
        step();
        chk("sig2", 32'(out_sig), 32'h00);
        send(2'd2, 8'h00, 8'h11, 8'h11, 8'h00, 8'h11);
        step();
        chk("sig3", 32'(out_sig), 32'h11);
        chk("sig3_q", 32'(out_q), 32'h11);
        send(2'd2, 8'h00, 8'h11, 8'h11, 8'h00, 8'h11);
        step();
        chk("sig4", 32'(out_sig), 32'h33);
        send(2'd0, 8'h00, 8'h11, 8'h11, 8'h00, 8'h11);
        step();
        chk("sig_pass_hold", 32'(out_sig), 32'h33);
        step();
        chk("txn9", 32'(txn_count), 32'd9);
        chk("sat_txn", 32'(s_txn), 32'd3);

        // Backpressure: A(PASS FF/00) and B(FOLD 00/FF) held, C(PASS 11/11) waits
        out_ready = 1'b0;
        set_ops(2'd0, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF);
        in_valid = 1'b1;
        step();
        set_ops(2'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        step();
        set_ops(2'd0, 8'h00, 8'h11, 8'h11, 8'h00, 8'h11);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_in_ready",  32'(in_ready),  32'h0);
            chk("bp_out_valid", 32'(out_valid), 32'h1);
            chk("bp_p",         32'(out_p),     32'hFF);
            chk("bp_q",         32'(out_q),     32'h00);
        end
        chk("bp_txn", 32'(txn_count), 32'd9);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("bp_b_p", 32'(out_p), 32'h00);
        chk("bp_b_q", 32'(out_q), 32'hFF);
        step();
        chk("bp_c_valid", 32'(out_valid), 32'h1);
        chk("bp_c_p", 32'(out_p), 32'h11);
        chk("bp_c_q", 32'(out_q), 32'h11);
        step();
        chk("bp_empty", 32'(out_valid), 32'h0);
        chk("bp_txn12", 32'(txn_count), 32'd12);
        chk("bp_sig", 32'(out_sig), 32'h33);
        chk("sat_txn5", 32'(s_txn), 32'd3);

        // Async reset with both stages full
        out_ready = 1'b0;
        set_ops(2'd0, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF);
        in_valid = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        chk("full_in_ready", 32'(in_ready), 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'h0);
        chk("arst_sig",       32'(out_sig),   32'h0);
        chk("arst_txn",       32'(txn_count), 32'h0);
        chk("arst_p",         32'(out_p),     32'h0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        chk("post_rst_in_ready", 32'(in_ready),  32'h1);
        chk("post_rst_empty",    32'(out_valid), 32'h0);
        send(2'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        chk("post_rst_lat1", 32'(out_valid), 32'h0);
        step();
        chk("post_rst_valid", 32'(out_valid), 32'h1);
        chk("post_rst_q",     32'(out_q),     32'hFF);
        chk("post_rst_txn0",  32'(txn_count), 32'h0);
        step();
        chk("post_rst_txn1",  32'(txn_count), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
